// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if
//   Bundles the command handshake from the loader front-end and the
//   instruction-memory write port of instr_encoder.
//
//   master : loader / testbench side (drives commands, observes writes)
//   slave  : encoder side
//
//   Signals
//     i_start, i_base_addr          arm encoder at a base address
//     i_valid / o_ready             command handshake
//     i_mnemonic, i_rs, i_rt, i_rd,
//     i_shamt, i_imm, i_target,
//     i_last                        symbolic command fields
//     o_wr_en, o_wr_addr, o_wr_data instruction-memory write port
//     o_count, o_err, o_done        status
// ---------------------------------------------------------------------------
interface instr_encoder_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8,
    parameter int NB_MNEM = 6
);
    logic               i_start;
    logic [NB_ADDR-1:0] i_base_addr;
    logic               i_valid;
    logic               o_ready;
    logic [NB_MNEM-1:0] i_mnemonic;
    logic [4:0]         i_rs;
    logic [4:0]         i_rt;
    logic [4:0]         i_rd;
    logic [4:0]         i_shamt;
    logic [15:0]        i_imm;
    logic [25:0]        i_target;
    logic               i_last;
    logic               o_wr_en;
    logic [NB_ADDR-1:0] o_wr_addr;
    logic [NB_DATA-1:0] o_wr_data;
    logic [NB_ADDR:0]   o_count;
    logic               o_err;
    logic               o_done;

    modport master (
        output i_start, i_base_addr, i_valid, i_mnemonic,
               i_rs, i_rt, i_rd, i_shamt, i_imm, i_target, i_last,
        input  o_ready, o_wr_en, o_wr_addr, o_wr_data,
               o_count, o_err, o_done
    );

    modport slave (
        input  i_start, i_base_addr, i_valid, i_mnemonic,
               i_rs, i_rt, i_rd, i_shamt, i_imm, i_target, i_last,
        output o_ready, o_wr_en, o_wr_addr, o_wr_data,
               o_count, o_err, o_done
    );
endinterface

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Sequential MIPS-I instruction encoder. Accepts symbolic commands
//   (mnemonic code + fields) over a valid/ready handshake, packs each into a
//   32-bit word and writes it to consecutive instruction-memory addresses
//   starting at the base address given with i_start. One word per two
//   cycles: the accept edge registers the encoded word, the following cycle
//   is the single-cycle write strobe.
//
//   Ports
//     clk   : clock
//     i_rst : synchronous, active-high reset
//     bus   : instr_encoder_if.slave (command handshake, write port, status)
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8,
    parameter int NB_MNEM = 6
) (
    input  logic                  clk,
    input  logic                  i_rst,
    instr_encoder_if.slave        bus
);

    // Mnemonic codes
    localparam logic [NB_MNEM-1:0] MN_SLL  = NB_MNEM'(0);
    localparam logic [NB_MNEM-1:0] MN_SRL  = NB_MNEM'(1);
    localparam logic [NB_MNEM-1:0] MN_SRA  = NB_MNEM'(2);
    localparam logic [NB_MNEM-1:0] MN_SLLV = NB_MNEM'(3);
    localparam logic [NB_MNEM-1:0] MN_SRLV = NB_MNEM'(4);
    localparam logic [NB_MNEM-1:0] MN_SRAV = NB_MNEM'(5);
    localparam logic [NB_MNEM-1:0] MN_ADDU = NB_MNEM'(6);
    localparam logic [NB_MNEM-1:0] MN_SUBU = NB_MNEM'(7);
    localparam logic [NB_MNEM-1:0] MN_AND  = NB_MNEM'(8);
    localparam logic [NB_MNEM-1:0] MN_OR   = NB_MNEM'(9);
    localparam logic [NB_MNEM-1:0] MN_XOR  = NB_MNEM'(10);
    localparam logic [NB_MNEM-1:0] MN_NOR  = NB_MNEM'(11);
    localparam logic [NB_MNEM-1:0] MN_SLT  = NB_MNEM'(12);
    localparam logic [NB_MNEM-1:0] MN_JR   = NB_MNEM'(13);
    localparam logic [NB_MNEM-1:0] MN_JALR = NB_MNEM'(14);
    localparam logic [NB_MNEM-1:0] MN_LB   = NB_MNEM'(15);
    localparam logic [NB_MNEM-1:0] MN_LH   = NB_MNEM'(16);
    localparam logic [NB_MNEM-1:0] MN_LW   = NB_MNEM'(17);
    localparam logic [NB_MNEM-1:0] MN_LBU  = NB_MNEM'(18);
    localparam logic [NB_MNEM-1:0] MN_LHU  = NB_MNEM'(19);
    localparam logic [NB_MNEM-1:0] MN_LWU  = NB_MNEM'(20);
    localparam logic [NB_MNEM-1:0] MN_SB   = NB_MNEM'(21);
    localparam logic [NB_MNEM-1:0] MN_SH   = NB_MNEM'(22);
    localparam logic [NB_MNEM-1:0] MN_SW   = NB_MNEM'(23);
    localparam logic [NB_MNEM-1:0] MN_ADDI = NB_MNEM'(24);
    localparam logic [NB_MNEM-1:0] MN_ANDI = NB_MNEM'(25);
    localparam logic [NB_MNEM-1:0] MN_ORI  = NB_MNEM'(26);
    localparam logic [NB_MNEM-1:0] MN_XORI = NB_MNEM'(27);
    localparam logic [NB_MNEM-1:0] MN_LUI  = NB_MNEM'(28);
    localparam logic [NB_MNEM-1:0] MN_SLTI = NB_MNEM'(29);
    localparam logic [NB_MNEM-1:0] MN_BEQ  = NB_MNEM'(30);
    localparam logic [NB_MNEM-1:0] MN_BNE  = NB_MNEM'(31);
    localparam logic [NB_MNEM-1:0] MN_J    = NB_MNEM'(32);
    localparam logic [NB_MNEM-1:0] MN_JAL  = NB_MNEM'(33);
    localparam logic [NB_MNEM-1:0] MN_HALT = NB_MNEM'(63);

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic               legal;
        logic               halt;
        logic [NB_DATA-1:0] word;
    } enc_t;

    // Packs one symbolic command. Fields the instruction does not use are
    // forced to zero so the image is canonical regardless of what the
    // front-end left on those inputs.
    function automatic enc_t encode(
        input logic [NB_MNEM-1:0] mnem,
        input logic [4:0]         rs,
        input logic [4:0]         rt,
        input logic [4:0]         rd,
        input logic [4:0]         shamt,
        input logic [15:0]        imm,
        input logic [25:0]        target
    );
        enc_t       e;
        logic [5:0] code;
        e.legal = 1'b1;
        e.halt  = 1'b0;
        e.word  = '0;
        code    = 6'd0;
        case (mnem)
            // Constant shifts: rs unused
            MN_SLL, MN_SRL, MN_SRA: begin
                case (mnem)
                    MN_SLL:  code = 6'h00;
                    MN_SRL:  code = 6'h02;
                    default: code = 6'h03;
                endcase
                e.word = {6'b0, 5'b0, rt, rd, shamt, code};
            end
            // Register-register ALU ops: shamt unused
            MN_SLLV, MN_SRLV, MN_SRAV, MN_ADDU, MN_SUBU, MN_AND,
            MN_OR, MN_XOR, MN_NOR, MN_SLT: begin
                case (mnem)
                    MN_SLLV: code = 6'h04;
                    MN_SRLV: code = 6'h06;
                    MN_SRAV: code = 6'h07;
                    MN_ADDU: code = 6'h21;
                    MN_SUBU: code = 6'h23;
                    MN_AND:  code = 6'h24;
                    MN_OR:   code = 6'h25;
                    MN_XOR:  code = 6'h26;
                    MN_NOR:  code = 6'h27;
                    default: code = 6'h2A;
                endcase
                e.word = {6'b0, rs, rt, rd, 5'b0, code};
            end
            MN_JR:   e.word = {6'b0, rs, 15'b0, 6'h08};
            MN_JALR: e.word = {6'b0, rs, 5'b0, rd, 5'b0, 6'h09};
            MN_LB, MN_LH, MN_LW, MN_LBU, MN_LHU, MN_LWU, MN_SB, MN_SH,
            MN_SW, MN_ADDI, MN_ANDI, MN_ORI, MN_XORI, MN_SLTI,
            MN_BEQ, MN_BNE: begin
                case (mnem)
                    MN_LB:   code = 6'h20;
                    MN_LH:   code = 6'h21;
                    MN_LW:   code = 6'h23;
                    MN_LBU:  code = 6'h24;
                    MN_LHU:  code = 6'h25;
                    MN_LWU:  code = 6'h27;
                    MN_SB:   code = 6'h28;
                    MN_SH:   code = 6'h29;
                    MN_SW:   code = 6'h2B;
                    MN_ADDI: code = 6'h08;
                    MN_ANDI: code = 6'h0C;
                    MN_ORI:  code = 6'h0D;
                    MN_XORI: code = 6'h0E;
                    MN_SLTI: code = 6'h0A;
                    MN_BEQ:  code = 6'h04;
                    default: code = 6'h05;
                endcase
                e.word = {code, rs, rt, imm};
            end
            // LUI has no source register
            MN_LUI:  e.word = {6'h0F, 5'b0, rt, imm};
            MN_J:    e.word = {6'h02, target};
            MN_JAL:  e.word = {6'h03, target};
            MN_HALT: begin
                e.word = HALT_WORD;
                e.halt = 1'b1;
            end
            default: e.legal = 1'b0;
        endcase
        return e;
    endfunction

    state_t             state_q;
    state_t             state_d;
    enc_t               enc;
    logic               ready;
    logic               wr_en;
    logic               done;
    logic               accept_fire;

    logic [NB_ADDR-1:0] ptr_q;
    logic               addr_full_q;   // last address already written
    logic [NB_ADDR:0]   count_q;
    logic               err_q;
    logic [NB_DATA-1:0] cmd_word_p0;
    logic               cmd_last_p0;

    always_comb begin
        enc = encode(bus.i_mnemonic, bus.i_rs, bus.i_rt, bus.i_rd,
                     bus.i_shamt, bus.i_imm, bus.i_target);
    end

    assign accept_fire = ready && bus.i_valid;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        wr_en   = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) state_d = S_ACCEPT;
            end
            S_ACCEPT: begin
                ready = 1'b1;
                if (bus.i_valid && enc.legal) begin
                    // A legal command with no address left ends the program
                    state_d = addr_full_q ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                // Reset during the write cycle suppresses the strobe so a
                // half-issued write never reaches memory.
                wr_en   = !i_rst;
                state_d = cmd_last_p0 ? S_DONE : S_ACCEPT;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---- accept stage (p0): register encoded word; write stage: advance ----
    always_ff @(posedge clk) begin
        if (i_rst) begin
            ptr_q       <= '0;
            addr_full_q <= 1'b0;
            count_q     <= '0;
            err_q       <= 1'b0;
            cmd_word_p0 <= '0;
            cmd_last_p0 <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.i_start) begin
                        ptr_q       <= bus.i_base_addr;
                        addr_full_q <= 1'b0;
                        count_q     <= '0;
                        err_q       <= 1'b0;
                    end
                end
                S_ACCEPT: begin
                    if (accept_fire) begin
                        if (!enc.legal || addr_full_q) begin
                            err_q <= 1'b1;
                        end else begin
                            cmd_word_p0 <= enc.word;
                            cmd_last_p0 <= bus.i_last || enc.halt;
                        end
                    end
                end
                S_WRITE: begin
                    // Pointer saturates at the top address instead of wrapping
                    if (ptr_q == '1) begin
                        addr_full_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + NB_ADDR'(1);
                    end
                    count_q <= count_q + (NB_ADDR+1)'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ready   = ready;
    assign bus.o_wr_en   = wr_en;
    assign bus.o_wr_addr = ptr_q;
    assign bus.o_wr_data = cmd_word_p0;
    assign bus.o_count   = count_q;
    assign bus.o_err     = err_q;
    assign bus.o_done    = done;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Sequential MIPS instruction encoder, the inverse of the opcode/funct decode path. It accepts symbolic instruction commands (mnemonic code plus fields) over a valid/ready handshake and packs them into 32-bit MIPS-I words. It writes those words to consecutive instruction-memory addresses. It sits between the debug/loader front-end and instruction memory, so programs can be loaded without a pre-assembled binary.

Parameters:
NB_DATA, 32, instruction word width (fixed 32 for MIPS-I packing)
NB_ADDR, 8, instruction-memory word-address width
NB_MNEM, 6, mnemonic code width

Ports:
clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_start  in  1  arm encoder; load i_base_addr, clear count/err
i_base_addr  in  NB_ADDR  first write address
i_valid  in  1  command valid
o_ready  out  1  encoder can accept a command
i_mnemonic  in  NB_MNEM  mnemonic code (see Behaviour)
i_rs / i_rt / i_rd / i_shamt  in  5 each  register and shift fields
i_imm  in  16  immediate / branch offset
i_target  in  26  jump target
i_last  in  1  command is the final one of the program
o_wr_en  out  1  instruction-memory write strobe, 1 cycle
o_wr_addr  out  NB_ADDR  write address
o_wr_data  out  NB_DATA  encoded word
o_count  out  NB_ADDR+1  words written since i_start
o_err  out  1  sticky: illegal mnemonic or address overflow
o_done  out  1  1-cycle pulse on program completion

Behaviour:
- Reset (i_rst high at a clk edge): state IDLE. o_ready=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_count=0, o_err=0, o_done=0. Reset overrides everything, including mid-write; a pending write is dropped.
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE: o_ready=0. On i_start, load the address pointer from i_base_addr, clear o_count and o_err, go to ACCEPT.
- ACCEPT: o_ready=1. When i_valid && o_ready, register the fields and encode.
  - Legal mnemonic: go to WRITE.
  - Illegal mnemonic: set o_err, no write, count unchanged, stay in ACCEPT.
  - i_last is latched with the command.
- WRITE: o_ready=0. o_wr_en=1 for exactly one cycle, with o_wr_addr = pointer and o_wr_data = encoded word. Then pointer+1 and o_count+1.
  - If the latched last flag is set, or the mnemonic is HALT, go to DONE.
  - Otherwise return to ACCEPT.
- Throughput: one word per 2 cycles. Latency from accept edge to o_wr_en is 1 cycle.
- DONE: pulse o_done for 1 cycle, then go to IDLE. i_start in IDLE re-arms.
- Overflow: if a legal command is accepted after the write to address 2^NB_ADDR-1, set o_err, do not write, go to DONE. The pointer never wraps.
- i_start asserted outside IDLE is ignored.
- Encoding formats:
  - R-type: {000000, rs, rt, rd, shamt, funct}
  - I-type: {op, rs, rt, imm}
  - J-type: {op, target}
- Mnemonic codes 0-14 are R-type, funct in hex:
  - 0 SLL 00, 1 SRL 02, 2 SRA 03
  - 3 SLLV 04, 4 SRLV 06, 5 SRAV 07
  - 6 ADDU 21, 7 SUBU 23, 8 AND 24, 9 OR 25, 10 XOR 26, 11 NOR 27, 12 SLT 2A
  - 13 JR 08, 14 JALR 09
- Mnemonic codes 15-31 are I-type, op in hex:
  - 15 LB 20, 16 LH 21, 17 LW 23, 18 LBU 24, 19 LHU 25, 20 LWU 27
  - 21 SB 28, 22 SH 29, 23 SW 2B
  - 24 ADDI 08, 25 ANDI 0C, 26 ORI 0D, 27 XORI 0E, 28 LUI 0F, 29 SLTI 0A
  - 30 BEQ 04, 31 BNE 05
- J-type and special codes:
  - 32 J 02, 33 JAL 03
  - 63 HALT: word 32'hFFFF_FFFF, implies last
  - All other codes are illegal.
- Field forcing (unused fields written as zero, inputs ignored):
  - SLL/SRL/SRA: rs=0.
  - SLLV..SLT: shamt=0.
  - JR: rt=rd=shamt=0.
  - JALR: rt=shamt=0.
  - LUI: rs=0.

Test Plan:
- i_start with base 0; ADDU rs=1 rt=2 rd=3 shamt=9 -> o_wr_en one cycle after accept, addr 0, data 32'h0022_1821, o_count=1.
- LW rs=29 rt=8 imm=0x0004, then J target=26'h10 -> addr 1 data 32'h8FA8_0004; addr 2 data 32'h0800_0010; o_ready low in each WRITE cycle.
- SLL rs=7 rt=1 rd=2 shamt=4 -> data 32'h0001_1100 (rs forced to 0).
- Mnemonic 40 -> no o_wr_en, o_err=1, o_count unchanged, o_ready stays 1. Next legal command still writes.
- NB_ADDR=2, base 0, five legal commands -> writes at addresses 0..3; fifth command: no write, o_err=1, o_done pulse, state IDLE.
- HALT -> data 32'hFFFF_FFFF, o_done pulses the cycle after the write. Separately, assert i_rst in the WRITE cycle -> no o_wr_en, all outputs at reset values next cycle.
